// File: rtl/sdram_port_arb.sv
// sdram_port_arb: round-robin arbiter that hands the SDRAM write path to one
// client write FIFO at a time. It issues one burst command per grant and steers
// the controller's per-word pop strobes to the granted FIFO's read enable.
module sdram_port_arb #(
    parameter  int unsigned NUM_PORTS = 4,
    parameter  int unsigned LEVEL_W   = 9,
    parameter  int unsigned BURST_LEN = 8,
    localparam int unsigned PORT_W    = $clog2(NUM_PORTS),
    localparam int unsigned LEN_W     = $clog2(BURST_LEN) + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_PORTS*LEVEL_W-1:0] i_fifo_level,
    input  logic [NUM_PORTS-1:0]         i_flush,
    output logic [NUM_PORTS-1:0]         o_fifo_rd_en,
    output logic                         o_cmd_valid,
    input  logic                         i_cmd_ready,
    output logic [PORT_W-1:0]            o_cmd_port,
    output logic [LEN_W-1:0]             o_cmd_len,
    input  logic                         i_data_pop,
    output logic                         o_busy,
    output logic                         o_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_cmd_valid;
    logic [PORT_W-1:0]  r_cmd_port;
    logic [LEN_W-1:0]   r_cmd_len;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [PORT_W-1:0]  r_rr_ptr;
    logic               r_busy;
    logic               r_err;

    logic [LEVEL_W-1:0] w_level [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_elig;
    logic               w_any;
    logic [PORT_W-1:0]  w_win;
    logic [LEVEL_W-1:0] w_win_level;
    logic [LEN_W-1:0]   w_win_len;
    logic [PORT_W-1:0]  w_next_ptr;
    logic               w_last_pop;

    // Unpack the per-port fill levels
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_level
        assign w_level[g] = i_fifo_level[g*LEVEL_W +: LEVEL_W];
    end

    // A port is eligible with a full burst buffered, or any data plus a flush request
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_elig[i] = (w_level[i] >= LEVEL_W'(BURST_LEN)) ||
                        (i_flush[i] && (w_level[i] != '0));
        end
    end

    // First eligible port scanning upward from the round-robin pointer, with wrap
    always_comb begin
        logic [PORT_W:0] v_idx;
        w_any = 1'b0;
        w_win = '0;
        v_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (PORT_W+1)'(k);
            if (v_idx >= (PORT_W+1)'(NUM_PORTS)) begin
                v_idx = v_idx - (PORT_W+1)'(NUM_PORTS);
            end
            if (!w_any && w_elig[v_idx[PORT_W-1:0]]) begin
                w_any = 1'b1;
                w_win = v_idx[PORT_W-1:0];
            end
        end
    end

    // Burst length for the winner: full burst, or whatever a flushing port holds
    always_comb begin
        w_win_level = w_level[w_win];
        w_win_len   = (w_win_level >= LEVEL_W'(BURST_LEN)) ? LEN_W'(BURST_LEN)
                                                            : LEN_W'(w_win_level);
    end

    // Pointer advance past the port just served, and end-of-burst detect
    always_comb begin
        w_next_ptr = (r_cmd_port == PORT_W'(NUM_PORTS - 1)) ? '0
                                                            : r_cmd_port + PORT_W'(1);
        w_last_pop = i_data_pop && (r_word_cnt == (r_cmd_len - LEN_W'(1)));
    end

    // Arbitration FSM with registered command outputs and sticky protocol error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_port  <= '0;
            r_cmd_len   <= '0;
            r_word_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (i_data_pop && (r_state != ST_XFER)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_cmd_port  <= w_win;
                        r_cmd_len   <= w_win_len;
                        r_cmd_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (i_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_word_cnt  <= '0;
                        r_state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (i_data_pop) begin
                        r_word_cnt <= r_word_cnt + LEN_W'(1);
                    end
                    if (w_last_pop) begin
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Pop strobes pass straight through to the granted FIFO, only during the data phase
    always_comb begin
        o_fifo_rd_en = '0;
        if ((r_state == ST_XFER) && i_data_pop) begin
            o_fifo_rd_en = NUM_PORTS'(1) << r_cmd_port;
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_port  = r_cmd_port;
    assign o_cmd_len   = r_cmd_len;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: a per-cycle vector table plus hand-written
// sequences for fairness, backpressure/gaps, mid-burst reset and sticky error.
module tb_sdram_port_arb;

    localparam int unsigned NP = 4;
    localparam int unsigned LW = 9;
    localparam int unsigned BL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP*LW-1:0] lvl;
    logic [NP-1:0] flush;
    logic [NP-1:0] rd_en;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_port;
    logic [3:0]    cmd_len;
    logic          data_pop;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdram_port_arb #(.NUM_PORTS(NP), .LEVEL_W(LW), .BURST_LEN(BL)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_fifo_level(lvl),
        .i_flush     (flush),
        .o_fifo_rd_en(rd_en),
        .o_cmd_valid (cmd_valid),
        .i_cmd_ready (cmd_ready),
        .o_cmd_port  (cmd_port),
        .o_cmd_len   (cmd_len),
        .i_data_pop  (data_pop),
        .o_busy      (busy),
        .o_err       (err)
    );

    typedef struct {
        logic [NP*LW-1:0] lvl;
        logic [3:0]       flush;
        logic             rdy;
        logic             pop;
        logic             ev;
        logic [1:0]       ep;
        logic [3:0]       el;
        logic [3:0]       erd;
        logic             eb;
        logic             ee;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [NP*LW-1:0] mk(input int a0, input int a1, input int a2, input int a3);
        return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
    endfunction

    task automatic add(input logic [NP*LW-1:0] l, input logic [3:0] f, input logic r, input logic p,
                       input logic ev, input logic [1:0] ep, input logic [3:0] el,
                       input logic [3:0] erd, input logic eb, input logic ee);
        vec_t v;
        v.lvl = l; v.flush = f; v.rdy = r; v.pop = p;
        v.ev = ev; v.ep = ep; v.el = el; v.erd = erd; v.eb = eb; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lvl = '0; flush = '0; cmd_ready = 1'b1; data_pop = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lvl = '0; flush = '0; cmd_ready = 1'b1; data_pop = 1'b0;
        #1;
        next_cyc();
        next_cyc();
        // Reset state, sampled while reset is still asserted
        chk("rst valid", 32'(cmd_valid), 0);
        chk("rst port",  32'(cmd_port), 0);
        chk("rst len",   32'(cmd_len), 0);
        chk("rst rd_en", 32'(rd_en), 0);
        chk("rst busy",  32'(busy), 0);
        chk("rst err",   32'(err), 0);
        rst = 1'b0;

        // Single full burst on port 1, then pointer at 2 picks port 3 over port 1
        add(mk(0,8,0,0), 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        add(mk(0,8,0,0), 4'b0000, 1, 0,  1, 1, 8, 4'b0000, 1, 0);
        for (int i = 0; i < 8; i++)
            add(mk(0,0,0,0), 4'b0000, 1, 1,  0, 0, 0, 4'b0010, 1, 0);
        add(mk(0,0,0,0), 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        add(mk(0,8,0,8), 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        add(mk(0,8,0,8), 4'b0000, 0, 0,  1, 3, 8, 4'b0000, 1, 0);
        add(mk(0,8,0,8), 4'b0000, 1, 0,  1, 3, 8, 4'b0000, 1, 0);
        for (int i = 0; i < 8; i++)
            add(mk(0,0,0,0), 4'b0000, 1, 1,  0, 0, 0, 4'b1000, 1, 0);
        // Partial level without flush is ignored; with flush it drains 3 words
        add(mk(0,0,3,0), 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        add(mk(0,0,3,0), 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        add(mk(0,0,3,0), 4'b0100, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        add(mk(0,0,3,0), 4'b0100, 1, 0,  1, 2, 3, 4'b0000, 1, 0);
        for (int i = 0; i < 3; i++)
            add(mk(0,0,0,0), 4'b0000, 1, 1,  0, 0, 0, 4'b0100, 1, 0);
        add(mk(0,0,0,0), 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 0);
        // Pop while idle: no read enable, error flagged on the following cycle
        add(mk(0,0,0,0), 4'b0000, 1, 1,  0, 0, 0, 4'b0000, 0, 0);
        add(mk(0,0,0,0), 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0, 1);

        foreach (tbl[i]) begin
            lvl = tbl[i].lvl; flush = tbl[i].flush;
            cmd_ready = tbl[i].rdy; data_pop = tbl[i].pop;
            #1;
            chk($sformatf("v%0d valid", i), 32'(cmd_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d port", i), 32'(cmd_port), 32'(tbl[i].ep));
                chk($sformatf("v%0d len", i),  32'(cmd_len),  32'(tbl[i].el));
            end
            chk($sformatf("v%0d rd_en", i), 32'(rd_en), 32'(tbl[i].erd));
            chk($sformatf("v%0d busy", i),  32'(busy),  32'(tbl[i].eb));
            chk($sformatf("v%0d err", i),   32'(err),   32'(tbl[i].ee));
            next_cyc();
        end

        // Fairness: all ports full and held, grants rotate 0,1,2,3,0,1
        do_reset();
        lvl = mk(20,20,20,20);
        for (int b = 0; b < 6; b++) begin
            data_pop = 1'b0;
            #1;
            chk($sformatf("fair%0d idle valid", b), 32'(cmd_valid), 0);
            next_cyc();
            chk($sformatf("fair%0d valid", b), 32'(cmd_valid), 1);
            chk($sformatf("fair%0d port", b), 32'(cmd_port), 32'(b % 4));
            chk($sformatf("fair%0d len", b), 32'(cmd_len), 8);
            next_cyc();
            data_pop = 1'b1;
            for (int w = 0; w < 8; w++) begin
                #1;
                chk($sformatf("fair%0d w%0d rd_en", b, w), 32'(rd_en), 32'(1 << (b % 4)));
                next_cyc();
            end
        end
        data_pop = 1'b0;
        #1;
        chk("fair err", 32'(err), 0);

        // Backpressure holds the command stable; alternate-cycle pops drain 8 words
        do_reset();
        lvl = mk(8,0,0,0); cmd_ready = 1'b0;
        #1;
        chk("bp idle valid", 32'(cmd_valid), 0);
        next_cyc();
        for (int j = 0; j < 5; j++) begin
            if (j == 2) lvl = mk(20,8,0,0);
            #1;
            chk($sformatf("bp%0d valid", j), 32'(cmd_valid), 1);
            chk($sformatf("bp%0d port", j), 32'(cmd_port), 0);
            chk($sformatf("bp%0d len", j), 32'(cmd_len), 8);
            next_cyc();
        end
        cmd_ready = 1'b1;
        #1;
        chk("bp accept valid", 32'(cmd_valid), 1);
        next_cyc();
        lvl = '0;
        for (int j = 0; j < 15; j++) begin
            data_pop = (j % 2 == 0);
            #1;
            chk($sformatf("gap%0d rd_en", j), 32'(rd_en), (j % 2 == 0) ? 32'd1 : 32'd0);
            if (j == 13) chk("gap busy before last", 32'(busy), 1);
            next_cyc();
        end
        data_pop = 1'b0;
        #1;
        chk("gap done busy", 32'(busy), 0);
        chk("gap done valid", 32'(cmd_valid), 0);
        chk("gap err", 32'(err), 0);

        // Reset mid-burst on port 1 after a port 0 burst moved the pointer to 1
        do_reset();
        lvl = mk(8,0,0,0);
        next_cyc();
        chk("mid p0 port", 32'(cmd_port), 0);
        next_cyc();
        lvl = '0; data_pop = 1'b1;
        for (int w = 0; w < 8; w++) next_cyc();
        data_pop = 1'b0;
        lvl = mk(0,8,0,0);
        next_cyc();
        #1;
        chk("mid p1 valid", 32'(cmd_valid), 1);
        chk("mid p1 port", 32'(cmd_port), 1);
        next_cyc();
        lvl = '0; data_pop = 1'b1;
        for (int w = 0; w < 4; w++) begin
            #1;
            chk($sformatf("mid w%0d rd_en", w), 32'(rd_en), 32'b0010);
            next_cyc();
        end
        rst = 1'b1; data_pop = 1'b0; lvl = mk(8,8,0,0);
        next_cyc();
        rst = 1'b0; data_pop = 1'b1;
        #1;
        chk("mid post rd_en", 32'(rd_en), 0);
        chk("mid post valid", 32'(cmd_valid), 0);
        chk("mid post busy", 32'(busy), 0);
        chk("mid post err", 32'(err), 0);
        next_cyc();
        // Pointer cleared by reset: port 0 wins over port 1; error from idle pop
        data_pop = 1'b0;
        #1;
        chk("err set", 32'(err), 1);
        chk("mid regrant valid", 32'(cmd_valid), 1);
        chk("mid regrant port", 32'(cmd_port), 0);
        next_cyc();
        lvl = '0; data_pop = 1'b1;
        for (int w = 0; w < 8; w++) begin
            #1;
            chk($sformatf("err burst w%0d rd_en", w), 32'(rd_en), 32'b0001);
            next_cyc();
        end
        data_pop = 1'b0;
        #1;
        chk("err sticky", 32'(err), 1);
        chk("err burst done busy", 32'(busy), 0);
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        #1;
        chk("err cleared", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Round-robin arbiter sharing the SDRAM controller's write path between NUM_PORTS client write FIFOs. It monitors each FIFO's binary fill level (after Gray-to-binary pointer conversion on the FIFO read side), picks one eligible port, and issues a single burst command to the SDRAM controller. During the data phase it steers the controller's per-word pop strobes to the granted FIFO's read enable. It sits between the client FIFO bank and the SDRAM command/data interface, in the SDRAM clock domain.

## Interface
- NUM_PORTS, 4: number of client FIFOs, 2..8
- LEVEL_W, 9: width of each FIFO fill-level input
- BURST_LEN, 8: full burst length in words, power of two, ≤ 2^LEVEL_W-1
- Clk  in  1  SDRAM-domain clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- Fifo_Level  in  NUM_PORTS*LEVEL_W  binary fill level per port; port i at bits [i*LEVEL_W +: LEVEL_W]
- Flush  in  NUM_PORTS  per-port request to drain a partial burst
- Fifo_Rd_En  out  NUM_PORTS  one-hot read enable to the granted FIFO
- Cmd_Valid  out  1  burst command pending
- Cmd_Ready  in  1  SDRAM controller accepts command
- Cmd_Port  out  clog2(NUM_PORTS)  granted port index
- Cmd_Len  out  clog2(BURST_LEN)+1  words in burst, 1..BURST_LEN
- Data_Pop  in  1  controller consumes one word this cycle
- Busy  out  1  high in any state other than IDLE
- Err  out  1  sticky: Data_Pop seen outside XFER

## Operation
- Eligibility of port i: Fifo_Level[i] ≥ BURST_LEN, or (Flush[i] and Fifo_Level[i] ≠ 0).
- Round-robin pointer Rr_Ptr (clog2(NUM_PORTS) bits). The winner is the first eligible port scanning Rr_Ptr, Rr_Ptr+1, …, modulo NUM_PORTS.
- States: IDLE, CMD, XFER.
  - IDLE: if any port is eligible, register the winner in Cmd_Port. Register Cmd_Len = BURST_LEN if level ≥ BURST_LEN, otherwise the level value. Go to CMD. Otherwise stay in IDLE.
  - CMD: Cmd_Valid=1. Cmd_Port and Cmd_Len are held stable. On Cmd_Valid && Cmd_Ready, clear Word_Cnt and go to XFER.
  - XFER: Fifo_Rd_En[Cmd_Port] = Data_Pop (combinational). All other bits are 0. Word_Cnt increments on each Data_Pop. On a Data_Pop with Word_Cnt == Cmd_Len-1: go to IDLE and set Rr_Ptr = Cmd_Port+1 (wrapping NUM_PORTS-1 → 0).
- The level is sampled only in IDLE. Level growth or Flush changes after the sample do not alter Cmd_Len.
- Data_Pop in IDLE or CMD sets Err. Err clears only on Rst. Fifo_Rd_En stays 0 in those states.
- Cmd_Len never exceeds the sampled level, so a FIFO is never read when empty.

## Timing
- Reset values: state IDLE, Cmd_Valid 0, Cmd_Port 0, Cmd_Len 0, Rr_Ptr 0, Word_Cnt 0, Busy 0, Err 0, Fifo_Rd_En 0.
- Rst is synchronous and has priority over every transition. An assertion mid-CMD or mid-XFER forces IDLE on the next edge and drops Cmd_Valid and Fifo_Rd_En immediately after that edge. A partially drained burst is abandoned.
- Latency, eligibility to command: eligibility in cycle N gives Cmd_Valid=1 in cycle N+1.
- Cmd_Ready tied high: CMD lasts exactly one cycle.
- Data phase: Fifo_Rd_En has zero-cycle latency from Data_Pop. The last pop of the burst in cycle M gives IDLE in cycle M+1. The earliest next Cmd_Valid is cycle M+2.
- Busy is registered and equals (state ≠ IDLE).
- Simultaneous eligibility: the round-robin order decides. The port just served has the lowest priority for the next arbitration.
- Data_Pop gaps in XFER are legal. Word_Cnt holds during gaps.

## Test plan
- Single full burst: Fifo_Level[1]=8, others 0, Cmd_Ready=1, Data_Pop continuous → Cmd_Valid one cycle with Cmd_Port=1, Cmd_Len=8. Fifo_Rd_En=4'b0010 for exactly 8 cycles. Return to IDLE. Rr_Ptr=2.
- Fairness: all four levels=20 and held, continuous pops → grant order 0,1,2,3,0,… with each burst 8 words and no port granted twice in a row.
- Flush partial: Fifo_Level[2]=3, Flush[2]=1 → Cmd_Len=3, exactly 3 read enables on bit 2. Fifo_Level[2]=3 with Flush=0 → no command issued.
- Backpressure and gaps: Cmd_Ready low for 5 cycles → Cmd_Valid, Cmd_Port and Cmd_Len stable throughout. Pops on alternate cycles → burst completes after the 8th pop, with no Fifo_Rd_En in gap cycles.
- Reset mid-burst: Rst high after the 4th of 8 pops → next cycle state IDLE, Fifo_Rd_En=0, Cmd_Valid=0, Rr_Ptr=0, Err=0.
- Protocol error: Data_Pop=1 while IDLE → Err=1 next cycle and stays set through subsequent good bursts until Rst. Fifo_Rd_En remains 0.
